// File: rtl/ram_bank_mmu_pkg.sv
// ram_bank_mmu_pkg
// Shared types and constants for the 6809 RAM bank MMU: lock state encoding,
// unlock key values, register-window offsets and slot-register field layout.
// Contains no ports; imported by ram_bank_mmu and mmu_lock_fsm.
package ram_bank_mmu_pkg;

  // Key-unlock state machine states.
  typedef enum logic [1:0] {
    LOCK_LOCKED   = 2'd0,
    LOCK_KEY1     = 2'd1,
    LOCK_UNLOCKED = 2'd2
  } lock_state_t;

  // Key sequence: KEY1_VAL then KEY2_VAL unlocks, RELOCK_VAL relocks at once.
  localparam logic [7:0] KEY1_VAL   = 8'h55;
  localparam logic [7:0] KEY2_VAL   = 8'hAA;
  localparam logic [7:0] RELOCK_VAL = 8'h00;

  // Register offsets past the slot registers (slot k lives at offset k).
  localparam int CTRL_OFS_FROM_SLOTS = 0;  // control/status at NUM_SLOTS + 0
  localparam int KEY_OFS_FROM_SLOTS  = 1;  // key at NUM_SLOTS + 1

  // Slot-register byte layout.
  localparam int SLOT_WP_BIT  = 7;
  localparam int SLOT_CHIP_HI = 6;
  localparam int SLOT_CHIP_LO = 5;
  localparam int SLOT_BANK_HI = 4;  // bank occupies [BANK_W-1:0], at most [4:0]

  // Control/status bit positions.
  localparam int CTRL_UNLOCKED_BIT = 0;
  localparam int CTRL_WPV_BIT      = 1;
  localparam int CTRL_IRQEN_BIT    = 2;

  // Slot state is stored in its register byte layout; bank bits above
  // BANK_W are held at zero so the stored byte is also the readback value.
  typedef struct packed {
    logic       wp;
    logic [1:0] chip;
    logic [4:0] bank;
  } slot_reg_t;

  // Convert a written byte into slot state, clearing bank bits above bank_w.
  function automatic slot_reg_t slot_from_byte(input logic [7:0] b, input int bank_w);
    slot_reg_t  s;
    logic [4:0] mask;
    mask   = 5'h1F >> (5 - bank_w);
    s.wp   = b[SLOT_WP_BIT];
    s.chip = b[SLOT_CHIP_HI:SLOT_CHIP_LO];
    s.bank = b[SLOT_BANK_HI:0] & mask;
    return s;
  endfunction

endpackage

// File: rtl/ram_bank_mmu_lock_fsm.sv
// mmu_lock_fsm
// Key-unlock state machine with automatic relock counter.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   key_wr          - one-cycle strobe: CPU write to the key register
//   key_data [7:0]  - data written to the key register
//   unlocked        - registered, high while the state is UNLOCKED
module mmu_lock_fsm
  import ram_bank_mmu_pkg::*;
#(
  parameter int RELOCK_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_wr,
  input  logic [7:0] key_data,
  output logic       unlocked
);

  localparam int CTR_W = (RELOCK_CYCLES > 2) ? $clog2(RELOCK_CYCLES) : 1;
  localparam logic [CTR_W-1:0] RELOAD_VAL = CTR_W'(RELOCK_CYCLES - 1);
  localparam logic [CTR_W-1:0] CTR_ZERO   = {CTR_W{1'b0}};

  lock_state_t      state_r, state_s;
  logic [CTR_W-1:0] ctr_r, ctr_s;

  // State, relock counter and unlocked flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= LOCK_LOCKED;
      ctr_r    <= CTR_ZERO;
      unlocked <= 1'b0;
    end else begin
      state_r  <= state_s;
      ctr_r    <= ctr_s;
      unlocked <= (state_s == LOCK_UNLOCKED);
    end
  end

  // Next-state and counter logic. A key write in UNLOCKED takes priority
  // over expiry, so any non-relock key value refreshes the window.
  always_comb begin
    state_s = state_r;
    ctr_s   = ctr_r;
    case (state_r)
      LOCK_LOCKED: begin
        ctr_s = CTR_ZERO;
        if (key_wr && (key_data == KEY1_VAL)) begin
          state_s = LOCK_KEY1;
        end else begin
          state_s = LOCK_LOCKED;
        end
      end
      LOCK_KEY1: begin
        ctr_s = CTR_ZERO;
        if (key_wr) begin
          if (key_data == KEY2_VAL) begin
            state_s = LOCK_UNLOCKED;
            ctr_s   = RELOAD_VAL;
          end else begin
            state_s = LOCK_LOCKED;
          end
        end else begin
          state_s = LOCK_KEY1;
        end
      end
      LOCK_UNLOCKED: begin
        if (key_wr) begin
          if (key_data == RELOCK_VAL) begin
            state_s = LOCK_LOCKED;
            ctr_s   = CTR_ZERO;
          end else begin
            state_s = LOCK_UNLOCKED;
            ctr_s   = RELOAD_VAL;
          end
        end else if (ctr_r == CTR_ZERO) begin
          state_s = LOCK_LOCKED;
          ctr_s   = CTR_ZERO;
        end else begin
          state_s = LOCK_UNLOCKED;
          ctr_s   = ctr_r - {{(CTR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = LOCK_LOCKED;
        ctr_s   = CTR_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/ram_bank_mmu.sv
// ram_bank_mmu
// Slot-based bank MMU between the 6809 bus and the RAM chips. The 64K CPU
// space is split into NUM_SLOTS slots; each slot selects a chip, a bank and
// an optional write protect. Slot registers live in a key-locked window.
// Optional feature macro: REG_READBACK_EN (when undefined, register reads
// return 8'hFF with dout_en low; writes and relock are unaffected).
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   adr, rnw, e       - CPU address, read-not-write, E phase
//   bus_stb, din      - register-access qualifier and write data
//   dout, dout_en     - registered register read data and its bus enable
//   ram_bank          - RAM high address bits for the current slot
//   ramcs_b           - active-low chip selects
//   ramoe_b, ramwe_b  - active-low RAM output / write enables
//   wp_irq            - registered write-protect violation interrupt
module ram_bank_mmu
  import ram_bank_mmu_pkg::*;
#(
  parameter int          NUM_SLOTS     = 4,
  parameter int          BANK_W        = 5,
  parameter int          NUM_CS        = 2,
  parameter logic [15:0] REG_BASE      = 16'hA010,
  parameter logic [3:0]  IO_NIBBLE     = 4'hA,
  parameter int          RELOCK_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       adr,
  input  logic              rnw,
  input  logic              e,
  input  logic              bus_stb,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              dout_en,
  output logic [BANK_W-1:0] ram_bank,
  output logic [NUM_CS-1:0] ramcs_b,
  output logic              ramoe_b,
  output logic              ramwe_b,
  output logic              wp_irq
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam logic [3:0] CTRL_OFS = 4'(NUM_SLOTS + CTRL_OFS_FROM_SLOTS);
  localparam logic [3:0] KEY_OFS  = 4'(NUM_SLOTS + KEY_OFS_FROM_SLOTS);

  slot_reg_t         slot_r [NUM_SLOTS];
  slot_reg_t         cur_slot_s;
  logic [SLOT_W-1:0] slot_idx_s;
  logic [15:0]       ofs_s;
  logic [3:0]        ofs_lo_s;
  logic              reg_hit_s;
  logic              io_hit_s;
  logic              ram_sel_s;
  logic              wr_s;
  logic              rd_s;
  logic              key_wr_s;
  logic              ctrl_wr_s;
  logic              viol_s;
  logic              unlocked_s;
  logic              irq_en_r;
  logic              wpv_r;

  assign slot_idx_s = adr[15 -: SLOT_W];
  assign cur_slot_s = slot_r[slot_idx_s];
  assign ofs_s      = adr - REG_BASE;
  assign ofs_lo_s   = ofs_s[3:0];
  assign reg_hit_s  = (adr >= REG_BASE) && (ofs_s <= 16'(NUM_SLOTS + 1));
  assign io_hit_s   = (adr[15:12] == IO_NIBBLE);
  assign ram_sel_s  = !reg_hit_s && !io_hit_s;

  assign wr_s      = bus_stb && !rnw && reg_hit_s;
  assign rd_s      = bus_stb && rnw && reg_hit_s;
  assign key_wr_s  = wr_s && (ofs_lo_s == KEY_OFS);
  assign ctrl_wr_s = wr_s && (ofs_lo_s == CTRL_OFS);

  // Violation is any write strobe into a protected slot of decoded RAM,
  // independent of bus_stb.
  assign viol_s = e && !rnw && cur_slot_s.wp && ram_sel_s;

  assign ram_bank = cur_slot_s.bank[BANK_W-1:0];
  assign ramoe_b  = !rnw;
  assign ramwe_b  = rnw || !e || cur_slot_s.wp;

  // Chip-select decode; a chip number with no matching chip selects nothing.
  always_comb begin
    ramcs_b = {NUM_CS{1'b1}};
    for (int i = 0; i < NUM_CS; i++) begin
      if (ram_sel_s && (cur_slot_s.chip == 2'(i))) begin
        ramcs_b[i] = 1'b0;
      end else begin
        ramcs_b[i] = 1'b1;
      end
    end
  end

  mmu_lock_fsm #(
    .RELOCK_CYCLES(RELOCK_CYCLES)
  ) u_lock (
    .clk      (clk),
    .reset    (reset),
    .key_wr   (key_wr_s),
    .key_data (din),
    .unlocked (unlocked_s)
  );

  // Slot registers: reset to an identity map, writable only while unlocked.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        slot_r[k] <= slot_from_byte(8'(k), BANK_W);
      end
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (wr_s && unlocked_s && (ofs_lo_s == 4'(k))) begin
          slot_r[k] <= slot_from_byte(din, BANK_W);
        end else begin
          slot_r[k] <= slot_r[k];
        end
      end
    end
  end

  // Control/status: irq_en gated by unlock, sticky violation with W1C
  // honoured in any state, set winning over clear, and the interrupt flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_r <= 1'b0;
      wpv_r    <= 1'b0;
      wp_irq   <= 1'b0;
    end else begin
      if (ctrl_wr_s && unlocked_s) begin
        irq_en_r <= din[CTRL_IRQEN_BIT];
      end else begin
        irq_en_r <= irq_en_r;
      end
      if (viol_s) begin
        wpv_r <= 1'b1;
      end else if (ctrl_wr_s && din[CTRL_WPV_BIT]) begin
        wpv_r <= 1'b0;
      end else begin
        wpv_r <= wpv_r;
      end
      wp_irq <= wpv_r && irq_en_r;
    end
  end

`ifdef REG_READBACK_EN
  logic [7:0] rd_data_s;

  // Register read mux; the key register and any unused offset read zero.
  always_comb begin
    rd_data_s = 8'h00;
    if (ofs_lo_s < 4'(NUM_SLOTS)) begin
      rd_data_s = slot_r[ofs_lo_s[SLOT_W-1:0]];
    end else if (ofs_lo_s == CTRL_OFS) begin
      rd_data_s = {5'b00000, irq_en_r, wpv_r, unlocked_s};
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Registered read data; enable lasts only the cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout    <= 8'h00;
      dout_en <= 1'b0;
    end else if (rd_s) begin
      dout    <= rd_data_s;
      dout_en <= 1'b1;
    end else begin
      dout    <= dout;
      dout_en <= 1'b0;
    end
  end
`else
  // Readback disabled: reads load all ones and never drive the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout    <= 8'h00;
      dout_en <= 1'b0;
    end else if (rd_s) begin
      dout    <= 8'hFF;
      dout_en <= 1'b0;
    end else begin
      dout    <= dout;
      dout_en <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ram_bank_mmu.sv
// tb_ram_bank_mmu
// Directed self-checking bench for ram_bank_mmu with default parameters.
// Works with or without REG_READBACK_EN; readback expectations follow it.
module tb_ram_bank_mmu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr;
  logic        rnw;
  logic        e;
  logic        bus_stb;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_en;
  logic [4:0]  ram_bank;
  logic [1:0]  ramcs_b;
  logic        ramoe_b;
  logic        ramwe_b;
  logic        wp_irq;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] RB = 16'hA010;

  always #5 clk = ~clk;

  ram_bank_mmu dut (
    .clk      (clk),
    .reset    (reset),
    .adr      (adr),
    .rnw      (rnw),
    .e        (e),
    .bus_stb  (bus_stb),
    .din      (din),
    .dout     (dout),
    .dout_en  (dout_en),
    .ram_bank (ram_bank),
    .ramcs_b  (ramcs_b),
    .ramoe_b  (ramoe_b),
    .ramwe_b  (ramwe_b),
    .wp_irq   (wp_irq)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    adr = 16'h0000; rnw = 1'b1; e = 1'b0; bus_stb = 1'b0; din = 8'h00;
  endtask

  task automatic reg_wr(input logic [3:0] ofs, input logic [7:0] data);
    adr = RB + {12'h000, ofs}; rnw = 1'b0; din = data; bus_stb = 1'b1;
    tick();
    idle();
  endtask

  task automatic reg_rd(input logic [3:0] ofs);
    adr = RB + {12'h000, ofs}; rnw = 1'b1; bus_stb = 1'b1;
    tick();
    idle();
  endtask

  // Read a register and check it against the readback value when enabled,
  // or against the floating-bus behaviour when readback is compiled out.
  task automatic rd_check(input string tag, input logic [3:0] ofs, input logic [7:0] exp);
    reg_rd(ofs);
`ifdef REG_READBACK_EN
    check({tag, "_dout"}, {8'h00, dout}, {8'h00, exp});
    check({tag, "_en"}, {15'h0000, dout_en}, 16'h0001);
`else
    check({tag, "_dout"}, {8'h00, dout}, 16'h00FF);
    check({tag, "_en"}, {15'h0000, dout_en}, 16'h0000);
`endif
  endtask

  // Present a bus cycle and check the combinational decode.
  task automatic access(input string tag, input logic [15:0] a, input logic r,
                        input logic [4:0] exp_bank, input logic [1:0] exp_cs);
    adr = a; rnw = r; e = 1'b1;
    #1;
    check({tag, "_bank"}, {11'h000, ram_bank}, {11'h000, exp_bank});
    check({tag, "_cs"}, {14'h0000, ramcs_b}, {14'h0000, exp_cs});
    check({tag, "_oe"}, {15'h0000, ramoe_b}, {15'h0000, ~r});
    idle();
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_dout", {8'h00, dout}, 16'h0000);
    check("rst_dout_en", {15'h0000, dout_en}, 16'h0000);
    check("rst_wp_irq", {15'h0000, wp_irq}, 16'h0000);

    // Identity map after reset.
    access("rst_s1", 16'h4000, 1'b1, 5'd1, 2'b10);
    access("rst_s0", 16'h0000, 1'b1, 5'd0, 2'b10);
    access("rst_s3", 16'hC000, 1'b1, 5'd3, 2'b10);
    adr = 16'h8000; rnw = 1'b0; e = 1'b1; #1;
    check("wr_unprot_we", {15'h0000, ramwe_b}, 16'h0000);
    e = 1'b0; #1;
    check("wr_e_low_we", {15'h0000, ramwe_b}, 16'h0001);
    idle(); #1;

    // Slot write while locked is ignored.
    reg_wr(4'd1, 8'h03);
    access("lock_s1", 16'h4000, 1'b1, 5'd1, 2'b10);
    rd_check("lock_rd_s1", 4'd1, 8'h01);

    // Unlock and program slots.
    reg_wr(4'd5, 8'h55);
    reg_wr(4'd5, 8'hAA);
    rd_check("unl_ctrl", 4'd4, 8'h01);
    rd_check("key_rd", 4'd5, 8'h00);
    reg_wr(4'd1, 8'h83);
    access("unl_s1", 16'h4000, 1'b1, 5'd3, 2'b10);
    reg_wr(4'd2, 8'h22);
    access("chip1_s2", 16'h8000, 1'b1, 5'd2, 2'b01);
    reg_wr(4'd3, 8'h45);
    access("chip2_s3", 16'hC000, 1'b1, 5'd5, 2'b11);
    reg_wr(4'd4, 8'h04);
    rd_check("irqen_ctrl", 4'd4, 8'h05);

    // Write-protect violation: write blocked, flag set, irq one cycle later.
    adr = 16'h4000; rnw = 1'b0; e = 1'b1; #1;
    check("wp_we_blocked", {15'h0000, ramwe_b}, 16'h0001);
    check("wp_cs", {14'h0000, ramcs_b}, 16'h0002);
    tick();
    idle();
    check("wp_irq_lat0", {15'h0000, wp_irq}, 16'h0000);
    tick();
    check("wp_irq_lat1", {15'h0000, wp_irq}, 16'h0001);
    rd_check("wpv_ctrl", 4'd4, 8'h07);
    reg_wr(4'd4, 8'h06);
    tick();
    check("w1c_irq", {15'h0000, wp_irq}, 16'h0000);
    rd_check("w1c_ctrl", 4'd4, 8'h05);

    // Relock key, then slot write rejected.
    reg_wr(4'd5, 8'h00);
    reg_wr(4'd2, 8'h00);
    access("relock_s2", 16'h8000, 1'b1, 5'd2, 2'b01);

    // Broken key sequence stays locked.
    reg_wr(4'd5, 8'h55);
    reg_wr(4'd5, 8'h12);
    reg_wr(4'd5, 8'hAA);
    reg_wr(4'd0, 8'h07);
    access("badkey_s0", 16'h0000, 1'b1, 5'd0, 2'b10);
    rd_check("badkey_ctrl", 4'd4, 8'h04);

    // Automatic relock: a write on the expiry cycle lands, the next does not.
    reg_wr(4'd5, 8'h55);
    reg_wr(4'd5, 8'hAA);
    repeat (4095) tick();
    reg_wr(4'd0, 8'h09);
    access("expiry_s0", 16'h0000, 1'b1, 5'd9, 2'b10);
    rd_check("expiry_ctrl", 4'd4, 8'h04);
    reg_wr(4'd0, 8'h0A);
    access("after_exp_s0", 16'h0000, 1'b1, 5'd9, 2'b10);

    // IO page and register window suppress chip selects.
    access("io_page", 16'hA000, 1'b1, 5'd2, 2'b11);
    access("pre_io", 16'h9FFF, 1'b1, 5'd2, 2'b01);
    access("post_io", 16'hB000, 1'b1, 5'd2, 2'b01);
    access("reg_base_cs", RB, 1'b1, 5'd2, 2'b11);
    rd_check("reg_base_rd", 4'd0, 8'h09);
    tick();
    check("dout_en_clear", {15'h0000, dout_en}, 16'h0000);
    reg_rd(4'd6);
    check("outside_win_en", {15'h0000, dout_en}, 16'h0000);

    // Reset in the middle of an unlocked window.
    reg_wr(4'd5, 8'h55);
    reg_wr(4'd5, 8'hAA);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_irq", {15'h0000, wp_irq}, 16'h0000);
    reg_wr(4'd1, 8'h1F);
    access("mid_rst_s1", 16'h4000, 1'b1, 5'd1, 2'b10);
    access("mid_rst_s2", 16'h8000, 1'b1, 5'd2, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bank_mmu.md
Name: ram_bank_mmu

Overview:
Parametrised successor to the fixed low-32K RAM mapping on the 6809 RAM board.
- Splits the CPU 64K space into NUM_SLOTS equal slots.
- Each slot maps to any bank of any of NUM_CS RAM chips, optionally write-protected.
- Mapping registers sit in a CPU-visible register window, guarded by a key-unlock state machine with automatic relock.
- Sits between the CPU bus pins and the RAM chip-select, bank-address and strobe pins, alongside the UART in the board CPLD.

Parameters:
NUM_SLOTS, 4, number of CPU address slots; power of two, 2..8
BANK_W, 5, width of ram_bank (high RAM address bits); 1..5
NUM_CS, 2, number of RAM chips; 1..4
REG_BASE, 16'hA010, byte address of the register window (NUM_SLOTS+2 bytes)
IO_NIBBLE, 4'hA, adr[15:12] value excluded from RAM decode (UART/IO page)
RELOCK_CYCLES, 4096, clk cycles after unlock before automatic relock; at least 2

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
adr  in  16  CPU address
rnw  in  1  CPU read-not-write
e  in  1  6809 E phase, used to gate ramwe_b
bus_stb  in  1  one-cycle pulse, qualifies adr/rnw/din for a register access
din  in  8  CPU write data
dout  out  8  register read data
dout_en  out  1  drive enable for dout onto the CPU data bus
ram_bank  out  BANK_W  bank bits to the RAM high address pins
ramcs_b  out  NUM_CS  active-low chip selects
ramoe_b  out  1  RAM output enable, active low
ramwe_b  out  1  RAM write enable, active low
wp_irq  out  1  registered write-protect violation interrupt, active high

Behaviour:
Decode
- slot = adr[15 -: log2(NUM_SLOTS)].
- reg_hit = adr within [REG_BASE, REG_BASE+NUM_SLOTS+1].
- io_hit = (adr[15:12] == IO_NIBBLE).
- Decode is combinational from registered slot state.
- ram_bank = slot_reg[slot].bank.
- ramcs_b: only bit slot_reg[slot].chip is low, and only when !reg_hit & !io_hit; otherwise all ones.
- ramoe_b = !rnw.
- ramwe_b = rnw | !e | wp, where wp = slot_reg[slot].wp.

Slot register format (offset k < NUM_SLOTS)
- [7] wp, [6:5] chip, [BANK_W-1:0] bank.
- Unused bits read 0.
- A chip value >= NUM_CS deasserts all ramcs_b.

Control/status register (offset NUM_SLOTS)
- [0] unlocked, read-only.
- [1] wp_violation, sticky, write-1-to-clear.
- [2] irq_en, read/write.

Key register (offset NUM_SLOTS+1): write-only; reads return 0.

Lock FSM; states LOCKED, KEY1, UNLOCKED. Key writes are bus_stb & !rnw at the key offset.
- LOCKED: write 8'h55 -> KEY1; any other key write stays LOCKED.
- KEY1: write 8'hAA -> UNLOCKED and load relock_ctr = RELOCK_CYCLES-1; any other key write -> LOCKED.
- UNLOCKED: write 8'h00 -> LOCKED.
- UNLOCKED: relock_ctr decrements every clk; on reaching 0 -> LOCKED.
- UNLOCKED: any other key write reloads the counter.
- Slot and irq_en writes take effect only when the registered state is UNLOCKED. The write uses the state current in that cycle, so a write in the same cycle as expiry is accepted; the relock applies on the next cycle.
- wp_violation W1C is honoured in any state.

Write-protect violation
- Set on a clk cycle where e & !rnw & wp & !reg_hit & !io_hit.
- Set wins over a simultaneous W1C.
- wp_irq registered = wp_violation & irq_en, one cycle latency.

Reads
- dout is registered.
- On bus_stb & rnw & reg_hit, dout <= selected register and dout_en <= 1.
- dout_en clears on the next cycle without bus_stb & rnw & reg_hit.

Reset values
- slot_reg[k] = {wp=0, chip=0, bank=k}, giving an identity map of the low banks.
- Lock state LOCKED; relock_ctr 0; wp_violation 0; irq_en 0.
- dout 0; dout_en 0; wp_irq 0.
- Reset mid-unlock returns to LOCKED.

Optional Feature:
REG_READBACK_EN
- Defined: slot and control registers are readable as above.
- Undefined: register reads give dout = 8'hFF and dout_en = 0 (bus floats); the relock counter and all write paths are unchanged.

Decomposition:
- Package ram_bank_mmu_pkg holds:
  - lock state enum;
  - key constants KEY1_VAL=8'h55, KEY2_VAL=8'hAA, RELOCK_VAL=8'h00;
  - register offset constants;
  - slot-register field positions.
- One sub-module, mmu_lock_fsm: lock FSM plus relock counter; outputs unlocked.

Test Plan:
- Reset, read adr 16'h4000 at e=1 -> ram_bank=1, ramcs_b=2'b10, ramoe_b=0.
- While locked, write 8'h03 to slot 1 register -> readback still 8'h01.
- Write key 8'h55, 8'hAA, then 8'h83 to slot 1 -> read 16'h4000 gives ram_bank=3; write to 16'h4000 keeps ramwe_b=1, wp_violation=1, and wp_irq=1 one cycle later when irq_en=1.
- Key 8'h55, 8'h12, 8'hAA -> still LOCKED.
- Unlock, idle RELOCK_CYCLES cycles -> unlocked bit reads 0; a slot write on the expiry cycle is accepted.
- Access 16'hA000 -> ramcs_b all ones; access REG_BASE -> ramcs_b all ones, dout_en=1 (or dout_en=0 without REG_READBACK_EN).
